cm162a_seq_counter: RTL and testbench

Registered state stage for the cm162a-class presettable counter logic. It holds the counter state and drives it back into the next-state network; this block also implements that next-state function itself, so it works standalone. It supports synchronous load, dual count enables, up/down direction and a cascade carry, and adds a registered wrap pulse and a saturating wrap counter for activity and power profiling in the synthesis benchmark set.

---
 rtl/cm162a_seq_counter.sv | 80 ++++++++
 tb/tb_cm162a_seq_counter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cm162a_seq_counter.sv
// Presettable up/down counter state register with its own next-state logic,
// cascade carry, per-digit terminal flags and a saturating wrap-event counter.
module cm162a_seq_counter #(
    parameter int unsigned DIGITS = 1,
    parameter int unsigned WRAP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    input  logic                  en_p,
    input  logic                  en_t,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   q,
    output logic                  rco,
    output logic [DIGITS-1:0]     digit_tc,
    output logic                  wrap,
    output logic [WRAP_W-1:0]     wrap_cnt
);

    localparam int unsigned WIDTH = 4 * DIGITS;

    logic [WIDTH-1:0]  q_q, q_d;
    logic              wrap_q, wrap_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [WIDTH-1:0]  term_val;
    logic              at_term;
    logic              step;

    assign term_val = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    assign at_term  = (q_q == term_val);
    assign step     = en_p & en_t;

    always_comb begin
        q_d        = q_q;
        wrap_d     = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end else if (step) begin
            // Full-width modular step gives the inter-digit carry for free.
            q_d = up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
            if (at_term) begin
                wrap_d = 1'b1;
                if (wrap_cnt_q != {WRAP_W{1'b1}}) begin
                    wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= '0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            q_q        <= q_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    always_comb begin
        digit_tc = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            digit_tc[k] = up ? (q_q[4*k +: 4] == 4'hF) : (q_q[4*k +: 4] == 4'h0);
        end
    end

    assign rco      = en_t & at_term;
    assign q        = q_q;
    assign wrap     = wrap_q;
    assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_cm162a_seq_counter.sv
// Scoreboard bench: one-digit counter with a 2-bit wrap counter, and a
// two-digit counter with the default 8-bit wrap counter.
module tb_cm162a_seq_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: DIGITS=1, WRAP_W=2
    logic       a_rst = 1'b0, a_clr = 1'b0, a_load = 1'b0;
    logic [3:0] a_d = '0;
    logic       a_en_p = 1'b0, a_en_t = 1'b0, a_up = 1'b1;
    logic [3:0] a_q;
    logic       a_rco, a_wrap;
    logic [0:0] a_tc;
    logic [1:0] a_cnt;

    // DUT 1: DIGITS=2, WRAP_W=8
    logic       b_rst = 1'b0, b_clr = 1'b0, b_load = 1'b0;
    logic [7:0] b_d = '0;
    logic       b_en_p = 1'b0, b_en_t = 1'b0, b_up = 1'b1;
    logic [7:0] b_q;
    logic       b_rco, b_wrap;
    logic [1:0] b_tc;
    logic [7:0] b_cnt;

    cm162a_seq_counter #(.DIGITS(1), .WRAP_W(2)) u_a (
        .clk(clk), .rst(a_rst), .clr(a_clr), .load(a_load), .d(a_d),
        .en_p(a_en_p), .en_t(a_en_t), .up(a_up), .q(a_q), .rco(a_rco),
        .digit_tc(a_tc), .wrap(a_wrap), .wrap_cnt(a_cnt)
    );

    cm162a_seq_counter #(.DIGITS(2), .WRAP_W(8)) u_b (
        .clk(clk), .rst(b_rst), .clr(b_clr), .load(b_load), .d(b_d),
        .en_p(b_en_p), .en_t(b_en_t), .up(b_up), .q(b_q), .rco(b_rco),
        .digit_tc(b_tc), .wrap(b_wrap), .wrap_cnt(b_cnt)
    );

    typedef struct {
        bit         sel;
        logic [7:0] q;
        logic       wrap;
        logic [7:0] cnt;
        logic       rco;
        logic [1:0] tc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic chk(input string name, input string field,
                       input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s.%s actual=%h required=%h", name, field, act, exp);
    endtask

    // Drive one cycle of inputs on the falling edge and queue the state
    // expected just after the following rising edge.
    task automatic step(input bit sel, input logic rst, input logic clr, input logic load,
                        input logic [7:0] d, input logic ep, input logic et, input logic up,
                        input logic [7:0] eq, input logic ewrap, input logic [7:0] ecnt,
                        input logic erco, input logic [1:0] etc, input string name);
        exp_t e;
        @(negedge clk);
        if (sel == 1'b0) begin
            a_rst = rst; a_clr = clr; a_load = load; a_d = d[3:0];
            a_en_p = ep; a_en_t = et; a_up = up;
        end else begin
            b_rst = rst; b_clr = clr; b_load = load; b_d = d;
            b_en_p = ep; b_en_t = et; b_up = up;
        end
        e.sel = sel; e.q = eq; e.wrap = ewrap; e.cnt = ecnt;
        e.rco = erco; e.tc = etc; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: every rising edge with a pending expectation is a DUT output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel == 1'b0) begin
                    chk(e.name, "q",    {4'b0, a_q},   e.q);
                    chk(e.name, "wrap", {7'b0, a_wrap}, {7'b0, e.wrap});
                    chk(e.name, "cnt",  {6'b0, a_cnt}, e.cnt);
                    chk(e.name, "rco",  {7'b0, a_rco}, {7'b0, e.rco});
                    chk(e.name, "tc",   {7'b0, a_tc},  {6'b0, e.tc});
                end else begin
                    chk(e.name, "q",    b_q,            e.q);
                    chk(e.name, "wrap", {7'b0, b_wrap}, {7'b0, e.wrap});
                    chk(e.name, "cnt",  b_cnt,          e.cnt);
                    chk(e.name, "rco",  {7'b0, b_rco},  {7'b0, e.rco});
                    chk(e.name, "tc",   {6'b0, b_tc},   {6'b0, e.tc});
                end
            end
        end
    end

    initial begin
        //   sel rst clr ld d      ep et up  q      wr cnt    rco tc
        // Reset with load asserted
        step(0, 1, 0, 1, 8'h0A, 0, 0, 1, 8'h00, 0, 8'h00, 0, 2'b00, "rst0");
        step(0, 1, 0, 1, 8'h0A, 0, 0, 1, 8'h00, 0, 8'h00, 0, 2'b00, "rst1");
        // Up wrap
        step(0, 0, 0, 1, 8'h0E, 0, 0, 1, 8'h0E, 0, 8'h00, 0, 2'b00, "ld_e");
        step(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h0F, 0, 8'h00, 1, 2'b01, "up_f");
        step(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h00, 1, 8'h01, 0, 2'b00, "up_0");
        step(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h01, 0, 8'h01, 0, 2'b00, "up_1");
        // Enable gating at q = F
        step(0, 0, 0, 1, 8'h0F, 0, 0, 1, 8'h0F, 0, 8'h01, 0, 2'b01, "ld_f");
        step(0, 0, 0, 0, 8'h00, 0, 0, 1, 8'h0F, 0, 8'h01, 0, 2'b01, "en00");
        step(0, 0, 0, 0, 8'h00, 1, 0, 1, 8'h0F, 0, 8'h01, 0, 2'b01, "en10");
        step(0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h0F, 0, 8'h01, 1, 2'b01, "en01");
        step(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h00, 1, 8'h02, 0, 2'b00, "en11");
        // Priority: clr+load, then load, then load beats a terminal count
        step(0, 0, 0, 1, 8'h0F, 0, 0, 1, 8'h0F, 0, 8'h02, 0, 2'b01, "pr_ldf");
        step(0, 0, 1, 1, 8'h05, 1, 1, 1, 8'h00, 0, 8'h02, 0, 2'b00, "pr_clrld");
        step(0, 0, 0, 1, 8'h05, 0, 0, 1, 8'h05, 0, 8'h02, 0, 2'b00, "pr_ld5");
        step(0, 0, 0, 1, 8'h0F, 0, 0, 1, 8'h0F, 0, 8'h02, 0, 2'b01, "pr_ldf2");
        step(0, 0, 0, 1, 8'h03, 1, 1, 1, 8'h03, 0, 8'h02, 0, 2'b00, "pr_ldwin");
        // Down wrap on one digit
        step(0, 0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 8'h02, 0, 2'b01, "dn_ld0");
        step(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h0F, 1, 8'h03, 0, 2'b00, "dn_wrap");
        // Saturation of the 2-bit wrap counter
        step(0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 8'h00, 0, 2'b00, "sat_rst");
        step(0, 0, 0, 1, 8'h0F, 0, 0, 1, 8'h0F, 0, 8'h00, 0, 2'b01, "sat_ld1");
        step(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h00, 1, 8'h01, 0, 2'b00, "sat_w1");
        step(0, 0, 0, 1, 8'h0F, 0, 0, 1, 8'h0F, 0, 8'h01, 0, 2'b01, "sat_ld2");
        step(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h00, 1, 8'h02, 0, 2'b00, "sat_w2");
        step(0, 0, 0, 1, 8'h0F, 0, 0, 1, 8'h0F, 0, 8'h02, 0, 2'b01, "sat_ld3");
        step(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h00, 1, 8'h03, 0, 2'b00, "sat_w3");
        step(0, 0, 0, 1, 8'h0F, 0, 0, 1, 8'h0F, 0, 8'h03, 0, 2'b01, "sat_ld4");
        step(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h00, 1, 8'h03, 0, 2'b00, "sat_w4");
        step(0, 0, 0, 1, 8'h0F, 0, 0, 1, 8'h0F, 0, 8'h03, 0, 2'b01, "sat_ld5");
        step(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h00, 1, 8'h03, 0, 2'b00, "sat_w5");
        step(0, 0, 1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 8'h03, 0, 2'b00, "sat_clr");
        step(0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 8'h00, 0, 2'b00, "sat_rst2");
        step(0, 0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 8'h00, 0, 2'b00, "a_idle");

        // Two-digit down count and cascade
        step(1, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 2'b11, "b_rst");
        step(1, 0, 0, 1, 8'h10, 0, 0, 0, 8'h10, 0, 8'h00, 0, 2'b01, "b_ld10");
        step(1, 0, 0, 0, 8'h00, 1, 1, 0, 8'h0F, 0, 8'h00, 0, 2'b10, "b_dn0f");
        for (int i = 14; i >= 0; i--) begin
            step(1, 0, 0, 0, 8'h00, 1, 1, 0, 8'(i), 0, 8'h00, (i == 0),
                 {1'b1, (i == 0)}, "b_dn");
        end
        step(1, 0, 0, 0, 8'h00, 1, 1, 0, 8'hFF, 1, 8'h01, 0, 2'b00, "b_dnwrap");
        step(1, 0, 0, 0, 8'h00, 0, 1, 1, 8'hFF, 0, 8'h01, 1, 2'b11, "b_dirflip");
        step(1, 0, 0, 0, 8'h00, 1, 1, 1, 8'h00, 1, 8'h02, 0, 2'b00, "b_upwrap");
        step(1, 0, 0, 1, 8'h0F, 0, 0, 1, 8'h0F, 0, 8'h02, 0, 2'b01, "b_ld0f");
        step(1, 0, 0, 0, 8'h00, 1, 1, 1, 8'h10, 0, 8'h02, 0, 2'b00, "b_carry");
        step(1, 1, 0, 1, 8'h55, 1, 1, 1, 8'h00, 0, 8'h00, 0, 2'b00, "b_midrst");
        step(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 8'h00, 0, 2'b00, "b_idle");

        repeat (3) @(negedge clk);
        chk("drain", "pending", 8'(sb.size()), 8'h00);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
